// File: rtl/seg7_scan_reader.sv
// Loopback monitor that decodes a multiplexed 7-segment bus back into one hex nibble per digit.
// Define SEG7_RD_ERRCNT_EN to add a saturating err_count output that counts undecodable captures.
module seg7_scan_reader #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    bad_pattern,
    output logic                    stale
`ifdef SEG7_RD_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] STAB_PRE = SCW'(STABLE_CYCLES - 2);
    localparam logic [15:0]    TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s2_q, dig_prev_q;
    logic [SCW-1:0]          stab_cnt_q, stab_cnt_d;
    logic                    cap_q, cap_d;
    logic [15:0]             to_cnt_q, to_cnt_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    frame_q, frame_d;
    logic                    bad_q, bad_d;
    logic                    stale_q, stale_d;
    logic                    same;
    logic                    onehot;
    logic [4:0]              dec;

    // Returns {hit, nibble}; hit is clear for blank and for unknown patterns.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E:   decode = {1'b1, 4'h0};
            7'h30:   decode = {1'b1, 4'h1};
            7'h6D:   decode = {1'b1, 4'h2};
            7'h79:   decode = {1'b1, 4'h3};
            7'h33:   decode = {1'b1, 4'h4};
            7'h5B:   decode = {1'b1, 4'h5};
            7'h5F:   decode = {1'b1, 4'h6};
            7'h70:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h73:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h1F:   decode = {1'b1, 4'hB};
            7'h4E:   decode = {1'b1, 4'hC};
            7'h3D:   decode = {1'b1, 4'hD};
            7'h4F:   decode = {1'b1, 4'hE};
            7'h47:   decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    // The capture strobe is registered, so the held sample in *_prev_q is what gets decoded.
    always_comb begin
        same       = (seg_s2_q == seg_prev_q) && (dig_s2_q == dig_prev_q);
        stab_cnt_d = stab_cnt_q;
        cap_d      = 1'b0;
        if (!same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + SCW'(1);
            cap_d      = (stab_cnt_q == STAB_PRE);
        end
    end

    always_comb begin
        dec      = decode(seg_prev_q);
        onehot   = $onehot(dig_prev_q);
        hex_d    = hex_q;
        valid_d  = valid_q;
        stale_d  = stale_q;
        frame_d  = 1'b0;
        bad_d    = 1'b0;
        to_cnt_d = to_cnt_q + 16'd1;
        if (cap_q && onehot) begin
            to_cnt_d = '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_prev_q[i]) begin
                    if (dec[4]) begin
                        hex_d[4*i +: 4] = dec[3:0];
                        valid_d[i]      = 1'b1;
                    end else begin
                        valid_d[i] = 1'b0;
                    end
                end
            end
            if (dec[4]) begin
                stale_d = 1'b0;
            end else if (seg_prev_q != 7'h00) begin
                bad_d = 1'b1;
            end
            frame_d = dig_prev_q[NUM_DIGITS-1] && (&valid_d);
        end else if (to_cnt_q == TO_LAST) begin
            valid_d  = '0;
            stale_d  = 1'b1;
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            seg_prev_q <= '0;
            dig_s1_q   <= '0;
            dig_s2_q   <= '0;
            dig_prev_q <= '0;
            stab_cnt_q <= '0;
            cap_q      <= 1'b0;
            to_cnt_q   <= '0;
            hex_q      <= '0;
            valid_q    <= '0;
            frame_q    <= 1'b0;
            bad_q      <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            seg_s1_q   <= seg_in;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            dig_s1_q   <= dig_sel;
            dig_s2_q   <= dig_s1_q;
            dig_prev_q <= dig_s2_q;
            stab_cnt_q <= stab_cnt_d;
            cap_q      <= cap_d;
            to_cnt_q   <= to_cnt_d;
            hex_q      <= hex_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            bad_q      <= bad_d;
            stale_q    <= stale_d;
        end
    end

`ifdef SEG7_RD_ERRCNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (bad_d && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign frame_valid = frame_q;
    assign bad_pattern = bad_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomized bench for seg7_scan_reader, checked every cycle against a run-length based reference model.
// Build with SEG7_RD_ERRCNT_EN defined to also cover err_count.
module tb_seg7_scan_reader;

    localparam int ND  = 4;
    localparam int SC  = 8;
    localparam int TO  = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [6:0]      seg_in = '0;
    logic [ND-1:0]   dig_sel = '0;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0]   digit_valid;
    logic            frame_valid;
    logic            bad_pattern;
    logic            stale;
`ifdef SEG7_RD_ERRCNT_EN
    logic [7:0]      err_count;
`endif

    seg7_scan_reader #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .bad_pattern (bad_pattern),
        .stale       (stale)
`ifdef SEG7_RD_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int framePulses = 0;

    logic [6:0] patTable [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model state: the expected outputs after the most recent rising edge.
    logic [3:0] mHex [ND];
    bit         mValid [ND];
    bit         mStale, mFrame, mBad;
    int         mErr, mSince;

    // A capture happens SC+2 edges after a sampled (seg,dig) run starts, if the run lasts SC edges.
    typedef struct {
        longint     due;
        logic [6:0] seg;
        logic [3:0] dig;
    } cap_t;
    cap_t        pend [$];
    longint      edgeNo, runStart;
    logic [10:0] runVal;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ND; i++) begin
            mHex[i]   = 4'h0;
            mValid[i] = 1'b0;
        end
        mStale   = 0;
        mFrame   = 0;
        mBad     = 0;
        mErr     = 0;
        mSince   = 0;
        edgeNo   = 0;
        runStart = -1000;
        runVal   = '0;
        pend.delete();
    endtask

    task automatic modelCapture(input logic [6:0] s, input logic [3:0] d, output bit resetTimer);
        int  digit;
        int  nib;
        bit  allValid;
        resetTimer = 0;
        if ($countones(d) != 1) return;
        resetTimer = 1;
        digit = 0;
        for (int i = 0; i < ND; i++) if (d[i]) digit = i;
        nib = -1;
        for (int n = 0; n < 16; n++) if (patTable[n] == s) nib = n;
        if (nib >= 0) begin
            mHex[digit]   = 4'(nib);
            mValid[digit] = 1;
            mStale        = 0;
        end else begin
            mValid[digit] = 0;
            if (s != 7'h00) begin
                mBad = 1;
                if (mErr < 255) mErr++;
            end
        end
        allValid = 1;
        for (int i = 0; i < ND; i++) if (!mValid[i]) allValid = 0;
        mFrame = (digit == ND - 1) && allValid;
    endtask

    always @(posedge clk or posedge rst) begin
        bit   resetTimer;
        cap_t c;
        if (rst) begin
            modelReset();
        end else begin
            edgeNo++;
            mFrame     = 0;
            mBad       = 0;
            resetTimer = 0;
            if ({seg_in, dig_sel} != runVal) begin
                runVal   = {seg_in, dig_sel};
                runStart = edgeNo;
            end
            if (edgeNo - runStart == SC - 1) begin
                pend.push_back('{edgeNo + 3, runVal[10:4], runVal[3:0]});
            end
            if (pend.size() > 0 && pend[0].due == edgeNo) begin
                c = pend.pop_front();
                modelCapture(c.seg, c.dig, resetTimer);
            end
            if (resetTimer) begin
                mSince = 0;
            end else begin
                mSince++;
                if (mSince == TO) begin
                    for (int i = 0; i < ND; i++) mValid[i] = 0;
                    mStale = 1;
                    mSince = 0;
                end
            end
        end
    end

    // Compare every output on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [4*ND-1:0] eHex;
        logic [ND-1:0]   eValid;
        for (int i = 0; i < ND; i++) begin
            eHex[4*i +: 4] = mHex[i];
            eValid[i]      = mValid[i];
        end
        checkOutput("hex_out", 32'(hex_out), 32'(eHex));
        checkOutput("digit_valid", 32'(digit_valid), 32'(eValid));
        checkOutput("frame_valid", 32'(frame_valid), 32'(mFrame));
        checkOutput("bad_pattern", 32'(bad_pattern), 32'(mBad));
        checkOutput("stale", 32'(stale), 32'(mStale));
`ifdef SEG7_RD_ERRCNT_EN
        checkOutput("err_count", 32'(err_count), 32'(mErr));
`endif
        if (frame_valid === 1'b1) framePulses++;
    end

    // Caller is always just after a rising edge; values are held for n edges.
    task automatic applyStimulus(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] s;
        logic [3:0] d;
        int         r;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_hex", 32'(hex_out), 32'h0);
        checkOutput("reset_valid", 32'(digit_valid), 32'h0);
        @(posedge clk);
        #1;
        seg_in  = 7'h7E;
        dig_sel = 4'b0001;
        rst     = 1'b0;

        // Single digit after reset, then walk digits 0..3 to build a frame.
        applyStimulus(7'h7E, 4'b0001, 14);
        checkOutput("t1_valid", 32'(digit_valid), 32'h1);
        framePulses = 0;
        applyStimulus(7'h30, 4'b0001, 12);
        applyStimulus(7'h6D, 4'b0010, 12);
        applyStimulus(7'h79, 4'b0100, 12);
        applyStimulus(7'h33, 4'b1000, 12);
        checkOutput("t2_hex", 32'(hex_out), 32'h4321);
        checkOutput("t2_frames", 32'(framePulses), 32'd1);

        // Toggling faster than the stability window must not capture.
        for (int k = 0; k < 10; k++) applyStimulus((k % 2) ? 7'h30 : 7'h7E, 4'b0001, 4);
        checkOutput("t3_hex", 32'(hex_out), 32'h4321);

        applyStimulus(7'h01, 4'b0100, 12);
        checkOutput("t4_valid", 32'(digit_valid), 32'b1011);

        // Non-one-hot strobes never capture, so the timeout fires.
        applyStimulus(7'h7E, 4'b0011, 120);
        checkOutput("t5_stale", 32'(stale), 32'h1);
        checkOutput("t5_valid", 32'(digit_valid), 32'h0);
        applyStimulus(7'h7E, 4'b0000, 20);

        // Reset three edges before a pending capture, inputs held through it.
        applyStimulus(7'h4F, 4'b0010, 7);
        doReset(2);
        applyStimulus(7'h4F, 4'b0010, 14);
        checkOutput("t6_hex", 32'(hex_out), 32'h00E0);
        checkOutput("t6_valid", 32'(digit_valid), 32'b0010);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       d = 4'(1 << $urandom_range(0, 3));
            else if (r == 8) d = 4'b0000;
            else             d = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)       s = patTable[$urandom_range(0, 15)];
            else if (r == 7) s = 7'h00;
            else             s = 7'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < ND; j++) applyStimulus(patTable[$urandom_range(0, 15)], 4'(1 << j), 12);
            end else begin
                applyStimulus(s, d, $urandom_range(1, 14));
            end
        end

`ifdef SEG7_RD_ERRCNT_EN
        for (int k = 0; k < 300; k++) applyStimulus(7'h01, 4'(1 << (k % 2)), 11);
        checkOutput("err_sat", 32'(err_count), 32'd255);
`endif

        applyStimulus(7'h00, 4'b0000, 20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
